// File: rtl/xbar_pkg.sv
// Shared types, default widths and helpers for the round-robin N x M cross-bar.
package xbar_pkg;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } xbar_cmd_e;

  localparam int XBAR_NM = 4;
  localparam int XBAR_NS = 4;
  localparam int XBAR_AW = 32;
  localparam int XBAR_DW = 32;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xbar_rr_nxm_if.sv
// Master-side and slave-side buses of the cross-bar. The "slave" modport is the
// fabric itself; "master" is the environment driving requests and slave replies.
interface xbar_rr_nxm_if import xbar_pkg::*; #(
  parameter int NM = XBAR_NM,
  parameter int NS = XBAR_NS,
  parameter int AW = XBAR_AW,
  parameter int DW = XBAR_DW
);

  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_cmd;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_ack;
  logic [NM*DW-1:0] m_rdata;
  logic [NM-1:0]    m_rvalid;
  logic [NS-1:0]    s_req;
  logic [NS-1:0]    s_cmd;
  logic [NS*AW-1:0] s_addr;
  logic [NS*DW-1:0] s_wdata;
  logic [NS-1:0]    s_ack;
  logic [NS*DW-1:0] s_rdata;

  modport master (
    output m_req, m_cmd, m_addr, m_wdata, s_ack, s_rdata,
    input  m_ack, m_rdata, m_rvalid, s_req, s_cmd, s_addr, s_wdata
  );

  modport slave (
    input  m_req, m_cmd, m_addr, m_wdata, s_ack, s_rdata,
    output m_ack, m_rdata, m_rvalid, s_req, s_cmd, s_addr, s_wdata
  );

endinterface

// File: rtl/xbar_rr_nxm_arb.sv
// Per-slave round-robin arbiter with grant locking while the slave stalls.
module rr_arbiter import xbar_pkg::*; #(
  parameter  int NM = XBAR_NM,
  localparam int IW = clog2_min1(NM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NM-1:0] cand,
  input  logic          s_req_stall,
  input  logic          s_ack,
  output logic          grant_vld,
  output logic [IW-1:0] grant_idx
);

  logic          lock_vld_q, lock_vld_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic [IW-1:0] ptr_q, ptr_d;

  // Grant: locked owner first, else first candidate at or above ptr (scan runs
  // downward so the lowest rotated distance overwrites last).
  always_comb begin
    logic [IW:0]   sum_v;
    logic [IW-1:0] idx_v;
    grant_vld = 1'b0;
    grant_idx = {IW{1'b0}};
    sum_v     = {(IW+1){1'b0}};
    idx_v     = {IW{1'b0}};
    if (lock_vld_q && cand[lock_idx_q]) begin
      grant_vld = 1'b1;
      grant_idx = lock_idx_q;
    end else begin
      for (int k = NM - 1; k >= 0; k--) begin
        sum_v     = {1'b0, ptr_q} + (IW+1)'(k);
        sum_v     = (sum_v >= (IW+1)'(NM)) ? sum_v - (IW+1)'(NM) : sum_v;
        idx_v     = sum_v[IW-1:0];
        grant_idx = cand[idx_v] ? idx_v : grant_idx;
        grant_vld = grant_vld | cand[idx_v];
      end
    end
  end

  // Lock and pointer next state
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    if (s_req_stall) begin
      lock_vld_d = 1'b1;
      lock_idx_d = grant_idx;
    end else if (s_ack || !cand[lock_idx_q]) begin
      lock_vld_d = 1'b0;
    end else begin
      lock_vld_d = lock_vld_q;
    end
    if (s_ack && grant_vld) begin
      ptr_d = (grant_idx == IW'(NM - 1)) ? {IW{1'b0}} : grant_idx + IW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_vld_q <= 1'b0;
      lock_idx_q <= {IW{1'b0}};
      ptr_q      <= {IW{1'b0}};
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
      ptr_q      <= ptr_d;
    end
  end

endmodule

// File: rtl/xbar_rr_nxm_chk.sv
// Simulation-only properties: one-hot grants and read-return timing.
module xbar_rr_nxm_chk #(
  parameter int NM = 4,
  parameter int NS = 4
) (
  input logic             clk,
  input logic             reset,
  input logic [NS*NM-1:0] grant_oh,
  input logic [NM-1:0]    rd_ack,
  input logic [NM-1:0]    m_rvalid
);

  for (genvar j = 0; j < NS; j++) begin : g_oh
    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset)
      $onehot0(grant_oh[j*NM +: NM]));
  end

  a_rvalid_after_rd_ack: assert property (@(posedge clk) disable iff (!reset)
    m_rvalid == $past(rd_ack));

endmodule

// File: rtl/xbar_rr_nxm.sv
// NM x NS cross-bar: address decode, per-slave round-robin arbitration with
// stall locking, combinational request/ack paths and a one-cycle read return.
module xbar_rr_nxm import xbar_pkg::*; #(
  parameter int NM = XBAR_NM,
  parameter int NS = XBAR_NS,
  parameter int AW = XBAR_AW,
  parameter int DW = XBAR_DW
) (
  input logic          clk,
  input logic          reset,
  xbar_rr_nxm_if.slave bus
);

  localparam int SW = $clog2(NS);
  localparam int IW = clog2_min1(NM);

  logic [SW-1:0]    tgt_s      [NM];
  logic [NM-1:0]    cand_s     [NS];
  logic [NS-1:0]    grant_vld_s;
  logic [IW-1:0]    grant_idx_s[NS];
  logic [NS*NM-1:0] grant_oh_s;
  logic [NS-1:0]    rd_vld_q, rd_vld_d;
  logic [IW-1:0]    rd_idx_q[NS];
  logic [IW-1:0]    rd_idx_d[NS];
  logic [NM-1:0]    rd_ack_s;

  // Decode; gating with reset forces every request path quiet during reset.
  always_comb begin
    for (int i = 0; i < NM; i++) begin
      tgt_s[i] = bus.m_addr[i*AW + AW - SW +: SW];
    end
    for (int j = 0; j < NS; j++) begin
      for (int i = 0; i < NM; i++) begin
        cand_s[j][i] = reset & bus.m_req[i] & (tgt_s[i] == SW'(j));
      end
    end
  end

  for (genvar j = 0; j < NS; j++) begin : g_arb
    rr_arbiter #(.NM(NM)) u_arb (
      .clk        (clk),
      .reset      (reset),
      .cand       (cand_s[j]),
      .s_req_stall(bus.s_req[j] & ~bus.s_ack[j]),
      .s_ack      (bus.s_ack[j]),
      .grant_vld  (grant_vld_s[j]),
      .grant_idx  (grant_idx_s[j])
    );
  end

  // Slave-side mux and master acks from the one-hot grant
  always_comb begin
    bus.s_req   = {NS{1'b0}};
    bus.s_cmd   = {NS{1'b0}};
    bus.s_addr  = {(NS*AW){1'b0}};
    bus.s_wdata = {(NS*DW){1'b0}};
    bus.m_ack   = {NM{1'b0}};
    grant_oh_s  = {(NS*NM){1'b0}};
    for (int j = 0; j < NS; j++) begin
      for (int i = 0; i < NM; i++) begin
        if (grant_vld_s[j] && (grant_idx_s[j] == IW'(i))) begin
          grant_oh_s[j*NM + i]    = 1'b1;
          bus.s_req[j]            = 1'b1;
          bus.s_cmd[j]            = bus.m_cmd[i];
          bus.s_addr[j*AW +: AW]  = bus.m_addr[i*AW +: AW];
          bus.s_wdata[j*DW +: DW] = bus.m_wdata[i*DW +: DW];
          bus.m_ack[i]            = bus.m_ack[i] | bus.s_ack[j];
        end else begin
          grant_oh_s[j*NM + i] = 1'b0;
        end
      end
    end
  end

  // Read-return tracking next state
  always_comb begin
    for (int j = 0; j < NS; j++) begin
      rd_vld_d[j] = bus.s_ack[j] & grant_vld_s[j] & (bus.s_cmd[j] == CMD_RD);
      rd_idx_d[j] = grant_idx_s[j];
    end
  end

  // Read-return tracking registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld_q <= {NS{1'b0}};
      for (int j = 0; j < NS; j++) rd_idx_q[j] <= {IW{1'b0}};
    end else begin
      rd_vld_q <= rd_vld_d;
      for (int j = 0; j < NS; j++) rd_idx_q[j] <= rd_idx_d[j];
    end
  end

  // Return mux: slave data reaches the master that owned last cycle's read ack
  always_comb begin
    bus.m_rvalid = {NM{1'b0}};
    bus.m_rdata  = {(NM*DW){1'b0}};
    for (int i = 0; i < NM; i++) begin
      for (int j = 0; j < NS; j++) begin
        if (rd_vld_q[j] && (rd_idx_q[j] == IW'(i))) begin
          bus.m_rvalid[i]         = 1'b1;
          bus.m_rdata[i*DW +: DW] = bus.s_rdata[j*DW +: DW];
        end else begin
          bus.m_rvalid[i] = bus.m_rvalid[i];
        end
      end
    end
  end

  assign rd_ack_s = bus.m_ack & ~bus.m_cmd;

  xbar_rr_nxm_chk #(.NM(NM), .NS(NS)) u_chk (
    .clk     (clk),
    .reset   (reset),
    .grant_oh(grant_oh_s),
    .rd_ack  (rd_ack_s),
    .m_rvalid(bus.m_rvalid)
  );

endmodule

// File: tb/tb_xbar_rr_nxm.sv
// Directed bench for xbar_rr_nxm: a 4x4/32-bit instance and an 8x2/64-bit one.
module tb_xbar_rr_nxm;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  xbar_rr_nxm_if #(.NM(4), .NS(4), .AW(32), .DW(32)) bus4 ();
  xbar_rr_nxm_if #(.NM(8), .NS(2), .AW(32), .DW(64)) bus8 ();

  xbar_rr_nxm #(.NM(4), .NS(4), .AW(32), .DW(32)) dut4 (
    .clk(clk), .reset(rst_n), .bus(bus4));
  xbar_rr_nxm #(.NM(8), .NS(2), .AW(32), .DW(64)) dut8 (
    .clk(clk), .reset(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus4.m_req = '0; bus4.m_cmd = '0; bus4.m_addr = '0; bus4.m_wdata = '0;
    bus4.s_ack = '0; bus4.s_rdata = '0;
    bus8.m_req = '0; bus8.m_cmd = '0; bus8.m_addr = '0; bus8.m_wdata = '0;
    bus8.s_ack = '0; bus8.s_rdata = '0;
  endtask

  task automatic drv4(input int i, input logic cmd, input logic [31:0] addr,
                      input logic [31:0] wd);
    bus4.m_req[i] = 1'b1;
    bus4.m_cmd[i] = cmd;
    bus4.m_addr[i*32 +: 32] = addr;
    bus4.m_wdata[i*32 +: 32] = wd;
  endtask

  task automatic drv8(input int i, input logic [31:0] addr, input logic [63:0] wd);
    bus8.m_req[i] = 1'b1;
    bus8.m_cmd[i] = 1'b1;
    bus8.m_addr[i*32 +: 32] = addr;
    bus8.m_wdata[i*64 +: 64] = wd;
  endtask

  // Drive at the falling edge, check one unit later, well before the rising edge.
  task automatic nxt();
    @(negedge clk);
    clr();
  endtask

  initial begin
    logic [3:0]  e4;
    logic [7:0]  e8;
    logic [63:0] wd8;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clr();

    // Reset: even with an acked request present, everything stays quiet.
    nxt();
    drv4(0, 1'b0, 32'h0000_0000, 32'h0);
    bus4.s_ack = 4'b0001;
    #1;
    chk("rst_m_ack", bus4.m_ack, 64'h0);
    chk("rst_s_req", bus4.s_req, 64'h0);
    chk("rst_m_rvalid", bus4.m_rvalid, 64'h0);
    chk("rst_m_rdata", bus4.m_rdata, 64'h0);
    nxt();
    rst_n = 1'b1;

    // Single read: m0 -> slave 1, data returned one cycle later only.
    nxt();
    drv4(0, 1'b0, 32'h4000_0010, 32'h0);
    bus4.s_ack = 4'b0010;
    #1;
    chk("rd_m_ack", bus4.m_ack, 64'h1);
    chk("rd_s_req", bus4.s_req, 64'h2);
    chk("rd_s_addr1", bus4.s_addr[32 +: 32], 64'h4000_0010);
    chk("rd_s_cmd", bus4.s_cmd, 64'h0);
    chk("rd_rvalid_T", bus4.m_rvalid, 64'h0);
    nxt();
    bus4.s_rdata[32 +: 32] = 32'hDEAD_BEEF;
    #1;
    chk("rd_rvalid_T1", bus4.m_rvalid, 64'h1);
    chk("rd_rdata0_T1", bus4.m_rdata[0 +: 32], 64'hDEAD_BEEF);
    nxt();
    bus4.s_rdata[32 +: 32] = 32'hDEAD_BEEF;
    #1;
    chk("rd_rvalid_T2", bus4.m_rvalid, 64'h0);
    chk("rd_rdata0_T2", bus4.m_rdata[0 +: 32], 64'h0);

    // Round-robin on slave 0 with an ack every cycle: 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      nxt();
      for (int i = 0; i < 4; i++) drv4(i, 1'b1, 32'h0000_0100 + 32'(i * 4), 32'(i));
      bus4.s_ack = 4'b0001;
      #1;
      e4 = 4'b0001 << (k % 4);
      chk("rr_m_ack", bus4.m_ack, 64'(e4));
      chk("rr_s_wdata0", bus4.s_wdata[0 +: 32], 64'(k % 4));
    end

    // Lock: m2 stalls on slave 3 while m0 competes; m2 keeps the slave.
    nxt();
    drv4(2, 1'b1, 32'hC000_0020, 32'h22);
    #1;
    chk("lk_s_addr3_c1", bus4.s_addr[96 +: 32], 64'hC000_0020);
    for (int c = 0; c < 2; c++) begin
      nxt();
      drv4(2, 1'b1, 32'hC000_0020, 32'h22);
      drv4(0, 1'b1, 32'hC000_0040, 32'h00);
      #1;
      chk("lk_s_addr3_stall", bus4.s_addr[96 +: 32], 64'hC000_0020);
      chk("lk_m_ack_stall", bus4.m_ack, 64'h0);
    end
    nxt();
    drv4(2, 1'b1, 32'hC000_0020, 32'h22);
    drv4(0, 1'b1, 32'hC000_0040, 32'h00);
    bus4.s_ack = 4'b1000;
    #1;
    chk("lk_m_ack_c4", bus4.m_ack, 64'h4);
    nxt();
    drv4(0, 1'b1, 32'hC000_0040, 32'h00);
    bus4.s_ack = 4'b1000;
    #1;
    chk("lk_m_ack_c5", bus4.m_ack, 64'h1);
    chk("lk_s_addr3_c5", bus4.s_addr[96 +: 32], 64'hC000_0040);

    // Parallel: four masters to four slaves in one cycle.
    nxt();
    drv4(0, 1'b1, 32'h0000_0004, 32'hA0A0_A0A0);
    drv4(1, 1'b0, 32'h4000_0008, 32'h0);
    drv4(2, 1'b0, 32'h8000_000C, 32'h0);
    drv4(3, 1'b1, 32'hC000_0010, 32'hB3B3_B3B3);
    bus4.s_ack = 4'b1111;
    #1;
    chk("par_m_ack", bus4.m_ack, 64'hF);
    chk("par_s_cmd", bus4.s_cmd, 64'h9);
    chk("par_s_wdata0", bus4.s_wdata[0 +: 32], 64'hA0A0_A0A0);
    chk("par_s_addr2", bus4.s_addr[64 +: 32], 64'h8000_000C);
    nxt();
    bus4.s_rdata = {32'hBBBB_BBBB, 32'h2222_2222, 32'h1111_1111, 32'hAAAA_AAAA};
    #1;
    chk("par_rvalid", bus4.m_rvalid, 64'h6);
    chk("par_rdata1", bus4.m_rdata[32 +: 32], 64'h1111_1111);
    chk("par_rdata2", bus4.m_rdata[64 +: 32], 64'h2222_2222);
    chk("par_rdata0", bus4.m_rdata[0 +: 32], 64'h0);
    chk("par_rdata3", bus4.m_rdata[96 +: 32], 64'h0);

    // Reset mid-transfer: m1 locked on slave 2, m0 read return pending.
    nxt();
    drv4(1, 1'b0, 32'h8000_0000, 32'h0);
    drv4(0, 1'b0, 32'h0000_0000, 32'h0);
    bus4.s_ack = 4'b0001;
    #1;
    chk("mr_m_ack", bus4.m_ack, 64'h1);
    chk("mr_s_req", bus4.s_req, 64'h5);
    nxt();
    drv4(1, 1'b0, 32'h8000_0000, 32'h0);
    bus4.s_rdata[0 +: 32] = 32'h5A5A_5A5A;
    #1;
    chk("mr_rvalid_pend", bus4.m_rvalid, 64'h1);
    chk("mr_s_req_lock", bus4.s_req, 64'h4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_rst_m_ack", bus4.m_ack, 64'h0);
    chk("mr_rst_rvalid", bus4.m_rvalid, 64'h0);
    chk("mr_rst_rdata0", bus4.m_rdata[0 +: 32], 64'h0);
    chk("mr_rst_s_req", bus4.s_req, 64'h0);
    nxt();
    rst_n = 1'b1;
    drv4(0, 1'b1, 32'h8000_0100, 32'h0);
    drv4(1, 1'b1, 32'h8000_0200, 32'h0);
    drv4(3, 1'b1, 32'h8000_0300, 32'h0);
    bus4.s_ack = 4'b0100;
    #1;
    chk("mr_post_m_ack", bus4.m_ack, 64'h1);
    chk("mr_post_s_addr2", bus4.s_addr[64 +: 32], 64'h8000_0100);
    chk("mr_post_rvalid", bus4.m_rvalid, 64'h0);

    // 8 masters, 2 slaves, 64-bit data: bit 31 alone selects slave 1.
    for (int k = 0; k < 9; k++) begin
      nxt();
      for (int i = 0; i < 8; i++) begin
        drv8(i, 32'h8000_0000 + 32'(i) * 32'h0800_0000, {32'hF0F0_0000 + 32'(i), 32'(i)});
      end
      bus8.s_ack = 2'b10;
      #1;
      e8  = 8'b0000_0001 << (k % 8);
      wd8 = {32'hF0F0_0000 + 32'(k % 8), 32'(k % 8)};
      chk("p8_m_ack", bus8.m_ack, 64'(e8));
      chk("p8_s_wdata1", bus8.s_wdata[64 +: 64], wd8);
      chk("p8_s_req", bus8.s_req, 64'h2);
    end
    nxt();
    drv8(5, 32'h7FFF_FFF0, 64'h0);
    #1;
    chk("p8_bit31_low", bus8.s_req, 64'h1);
    chk("p8_s_addr0", bus8.s_addr[0 +: 32], 64'h7FFF_FFF0);

    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xbar_rr_nxm.md
Name: xbar_rr_nxm

Overview:
- Parametrised successor of the 4x4 cross-bar: NM masters by NS slaves on the req/ack/cmd/addr/wdata/rdata bus.
- Sits between the CPU-side masters and the memory/peripheral slaves.
- Adds per-slave round-robin arbitration in place of fixed priority, and grant locking while a slave stalls.
- Adds a registered read-return path with an explicit m_rvalid strobe.
- Slave select = top SW = $clog2(NS) bits of the address.

Parameters:
- NM, 4, number of masters (>=2).
- NS, 4, number of slaves (power of two, >=2).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- m_req  in  NM  master request.
- m_cmd  in  NM  1 = write, 0 = read.
- m_addr  in  NM*AW  master addresses, master i at [i*AW +: AW].
- m_wdata  in  NM*DW  master write data.
- m_ack  out  NM  transfer accepted.
- m_rdata  out  NM*DW  read data, one cycle after read ack.
- m_rvalid  out  NM  qualifies m_rdata.
- s_req  out  NS  slave request.
- s_cmd  out  NS  slave command.
- s_addr  out  NS*AW  slave address (full address forwarded).
- s_wdata  out  NS*DW  slave write data.
- s_ack  in  NS  slave accepts transfer.
- s_rdata  in  NS*DW  slave read data, valid the cycle after s_ack on a read.

Behaviour:
- Decode: master i targets slave j when m_addr_i[AW-1 -: SW] == j. cand_j[i] = m_req[i] & target_i==j.
- Per-slave state: lock_vld, lock_idx (owner), ptr (round-robin pointer, $clog2(NM) bits), rd_vld, rd_idx.
- Grant, combinational:
  - lock_vld=1 and cand_j[lock_idx]=1: grant = lock_idx.
  - Otherwise: grant = first set bit of cand_j scanning from ptr upward, wrapping NM-1 -> 0.
  - No candidate: no grant.
- Slave drive: s_req/s_cmd/s_addr/s_wdata come from the granted master. With no grant, all are 0.
- Ack: m_ack[i] = s_ack[j] & (grant_j == i). A master addresses one slave per cycle, so at most one source drives each m_ack bit. No added latency, fully combinational path.
- Lock update (posedge clk):
  - s_req_j=1 & s_ack_j=0: lock_vld<=1, lock_idx<=grant.
  - s_ack_j=1, or the locked owner drops req or changes target: lock_vld<=0.
- Pointer: on s_ack_j, ptr <= (grant+1) mod NM. Otherwise ptr holds.
- Read return:
  - On s_ack_j with s_cmd_j=0: rd_vld<=1, rd_idx<=grant. Otherwise rd_vld<=0.
  - Next cycle: m_rdata_i = s_rdata_j and m_rvalid[i]=1 for the slave j with rd_vld & rd_idx==i.
  - No match: m_rdata_i=0, m_rvalid[i]=0. At most one match per master (one ack per master per cycle).
- Writes produce no rvalid.
- Back-to-back: a master may re-request the same or another slave in the cycle after ack; return and new grant are independent.
- Simultaneous: s_ack and a new competing req in the same cycle → the pointer advance takes effect next cycle.
- Fairness: each requesting master is served within NM-1 grants of the same slave.
- Reset (async, reset=0):
  - ptr=0, lock_vld=0, rd_vld=0.
  - Hence m_ack=0, m_rvalid=0, m_rdata=0, s_req=0 immediately.
  - A transfer in flight is dropped and no rvalid is issued.
- Assertions (simulation only): $onehot0 of each grant vector; m_rvalid only the cycle after a read ack.

Decomposition:
- xbar_pkg: `xbar_cmd_e` (CMD_RD=0, CMD_WR=1); function `clog2_min1`; default width constants.
- Sub-module `rr_arbiter #(NM)`:
  - Inputs: clk, reset, cand, s_req_stall, s_ack.
  - Outputs: grant_vld, grant_idx.
  - Holds lock and ptr. Instantiated NS times in a generate loop.
- The top level holds decode, muxes, rd tracking, and the return mux.

Test Plan:
- Single read: m0 reads 0x4000_0010 (slave 1), s_ack1 same cycle, s_rdata1=0xDEAD_BEEF next cycle → m_ack[0]=1 at T; m_rdata0=0xDEAD_BEEF and m_rvalid[0]=1 at T+1 only.
- Round-robin: m0..m3 hold requests to slave 0, slave acks every cycle → grant order 0,1,2,3,0. Each master gets exactly 1 ack per 4 cycles.
- Lock: m2 granted on slave 3 with s_ack3=0 for 3 cycles while m0 raises req → s_addr3 stays m2's address. m2 acked on cycle 4, then m0 granted.
- Parallel: m0→slave0 write, m1→slave1 read, m2→slave2 read, m3→slave3 write, all acked → 4 m_ack in one cycle. rvalid next cycle only on m1 and m2, each with its own slave's data.
- Reset mid-transfer: assert reset while m1 is locked on slave 2 and a read return is pending → all outputs 0 asynchronously. After release, ptr=0 and m0 wins the first contention.
- Param sweep: NM=8, NS=2, DW=64 → 8 masters to slave 1 rotate fairly. Address bit 31 alone selects the slave.
